// File: rtl/alu_operand_seq.sv
// alu_operand_seq: touchscreen-driven operand sequencer in front of the ALU.
// Successive entries load CONTROL, SRC_1 and SRC_2. The block then waits
// ALU_LAT cycles for the combinational ALU to settle, captures its result,
// pulses result_valid and bumps a wrapping operation counter.
//
// Handshake: input_valid is a one-cycle strobe with no ready; an entry is
// consumed in the cycle it is seen unless the sequencer is in S_EXEC or clear
// is high, in which case it is dropped. result_valid is a one-cycle strobe
// qualifying result_q and op_count, with no backpressure.
module alu_operand_seq #(
  parameter int CTRL_W  = 12,
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_valid,
  input  logic [DATA_W-1:0] input_value,
  input  logic              clear,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [DATA_W-1:0] result_q,
  output logic              result_valid,
  output logic [2:0]        seq_state,
  output logic [CNT_W-1:0]  op_count
);

  // Settle counter only needs to hold ALU_LAT-1; keep it at least 1 bit wide.
  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_CTRL = 3'd0,
    S_SRC1 = 3'd1,
    S_SRC2 = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
  logic [DATA_W-1:0]  src1_q,  src1_d;
  logic [DATA_W-1:0]  src2_q,  src2_d;
  logic [DATA_W-1:0]  res_q,   res_d;
  logic               rv_q,    rv_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [LAT_W-1:0]   lat_q,   lat_d;

  // Next-state and next-register computation; clear outranks any entry.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    res_d   = res_q;
    rv_d    = 1'b0;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    if (clear) begin
      state_d = S_CTRL;
    end else begin
      case (state_q)
        S_CTRL, S_DONE: begin
          if (input_valid) begin
            ctrl_d  = input_value[CTRL_W-1:0];
            state_d = S_SRC1;
          end
        end
        S_SRC1: begin
          if (input_valid) begin
            src1_d  = input_value;
            state_d = S_SRC2;
          end
        end
        S_SRC2: begin
          if (input_valid) begin
            src2_d  = input_value;
            lat_d   = LAT_LOAD;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          // Entries arriving here are dropped on purpose.
          if (lat_q == '0) begin
            res_d   = alu_result;
            rv_d    = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_DONE;
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
        default: state_d = S_CTRL;
      endcase
    end
  end

  // Register all state and outputs; synchronous reset aborts any capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CTRL;
      ctrl_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  assign alu_control  = ctrl_q;
  assign alu_src1     = src1_q;
  assign alu_src2     = src2_q;
  assign result_q     = res_q;
  assign result_valid = rv_q;
  assign seq_state    = state_q;
  assign op_count     = cnt_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Bench for alu_operand_seq: transaction-level reference model plus a
// result scoreboard drained by an independent monitor.
module tb_alu_operand_seq;

  localparam int CTRL_W  = 12;
  localparam int DATA_W  = 32;
  localparam int ALU_LAT = 2;
  localparam int CNT_W   = 8;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              input_valid = 1'b0;
  logic [DATA_W-1:0] input_value = '0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] alu_result;
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [DATA_W-1:0] result_q;
  logic              result_valid;
  logic [2:0]        seq_state;
  logic [CNT_W-1:0]  op_count;

  always #50 clk = ~clk;

  // Environment ALU: plain adder driven from the sequencer's operands.
  assign alu_result = alu_src1 + alu_src2;

  alu_operand_seq #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .input_valid(input_valid),
    .input_value(input_value), .clear(clear), .alu_result(alu_result),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .result_q(result_q), .result_valid(result_valid),
    .seq_state(seq_state), .op_count(op_count)
  );

  // ---------------- reference model ----------------
  // entries_seen: 0 = waiting for CONTROL, 1 = SRC_1, 2 = SRC_2,
  // 3 = settling, 4 = result held.
  int                m_phase = 0;
  logic [CTRL_W-1:0] m_ctrl = '0;
  logic [DATA_W-1:0] m_src1 = '0;
  logic [DATA_W-1:0] m_src2 = '0;
  logic [DATA_W-1:0] m_res = '0;
  int                m_cnt = 0;
  logic              m_rv = 1'b0;
  longint            cyc = 0;
  longint            deadline = -1;

  logic [DATA_W+CNT_W-1:0] exp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int rv_pulses = 0;

  task automatic model_edge(input logic iv, input logic [DATA_W-1:0] val,
                            input logic clr, input logic rst);
    cyc++;
    m_rv = 1'b0;
    if (rst) begin
      m_phase = 0; m_ctrl = '0; m_src1 = '0; m_src2 = '0; m_res = '0;
      m_cnt = 0; deadline = -1;
    end else if (clr) begin
      m_phase = 0; deadline = -1;
    end else if (m_phase == 0 || m_phase == 4) begin
      if (iv) begin m_ctrl = val[CTRL_W-1:0]; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (iv) begin m_src1 = val; m_phase = 2; end
    end else if (m_phase == 2) begin
      if (iv) begin m_src2 = val; m_phase = 3; deadline = cyc + ALU_LAT; end
    end else if (cyc == deadline) begin
      m_res = m_src1 + m_src2;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_rv = 1'b1;
      m_phase = 4;
      deadline = -1;
      exp_q.push_back({m_res, CNT_W'(m_cnt)});
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("seq_state",    64'(seq_state),    64'(m_phase));
    chk("alu_control",  64'(alu_control),  64'(m_ctrl));
    chk("alu_src1",     64'(alu_src1),     64'(m_src1));
    chk("alu_src2",     64'(alu_src2),     64'(m_src2));
    chk("result_q",     64'(result_q),     64'(m_res));
    chk("op_count",     64'(op_count),     64'(m_cnt));
    chk("result_valid", 64'(result_valid), 64'(m_rv));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, take the rising edge, check.
  task automatic step(input logic iv, input logic [DATA_W-1:0] val,
                      input logic clr, input logic rst);
    input_valid = iv; input_value = val; clear = clr; reset = rst;
    @(posedge clk);
    model_edge(iv, val, clr, rst);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_op(input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    idle(ALU_LAT);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [DATA_W+CNT_W-1:0] e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        rv_pulses++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected cyc=%0d actual result=0x%0h required no pulse",
                   cyc, result_q);
        end else begin
          e = exp_q.pop_front();
          if ({result_q, op_count} !== e) begin
            n_bad++;
            $display("FAIL sb_result cyc=%0d actual=0x%0h/0x%0h required=0x%0h/0x%0h",
                     cyc, result_q, op_count, e[DATA_W+CNT_W-1:CNT_W], e[CNT_W-1:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    @(negedge clk);

    // Reset for two cycles.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("reset_state", 64'(seq_state), 64'd0);
    idle(2);

    // Normal sequence 0x001, 0x5, 0x3 -> 0x8 after ALU_LAT cycles.
    p0 = rv_pulses;
    run_op(32'h001, 32'h5, 32'h3);
    chk("dir_result", 64'(result_q), 64'h8);
    chk("dir_count", 64'(op_count), 64'd1);
    chk("dir_state", 64'(seq_state), 64'd4);
    chk("dir_pulses", 64'(rv_pulses - p0), 64'd1);
    idle(2);

    // Entry 0xFF one cycle after SRC_2 is ignored.
    step(1'b1, 32'h0A2, 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'hFF, 1'b0, 1'b0);
    idle(ALU_LAT);
    chk("exec_drop_src2", 64'(alu_src2), 64'h20);
    chk("exec_drop_res", 64'(result_q), 64'h30);

    // clear in S_SRC2 together with an entry of 0x9.
    p0 = rv_pulses;
    step(1'b1, 32'h7, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b1, 32'h9, 1'b1, 1'b0);
    chk("clear_state", 64'(seq_state), 64'd0);
    chk("clear_src2", 64'(alu_src2), 64'h20);
    idle(ALU_LAT + 2);
    chk("clear_no_pulse", 64'(rv_pulses - p0), 64'd0);

    // Clear just before capture aborts it.
    p0 = rv_pulses;
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h3, 1'b0, 1'b0);
    idle(ALU_LAT - 1);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    chk("clear_exec_pulse", 64'(rv_pulses - p0), 64'd0);

    // Wrap: 256 operations from a fresh count.
    step(1'b0, '0, 1'b0, 1'b1);
    p0 = rv_pulses;
    for (int i = 0; i < 256; i++) run_op($urandom, $urandom, $urandom);
    @(negedge clk);
    chk("wrap_count", 64'(op_count), 64'd0);
    chk("wrap_pulses", 64'(rv_pulses - p0), 64'd256);

    // Reset on the capture edge.
    p0 = rv_pulses;
    step(1'b1, 32'h3, 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    idle(ALU_LAT - 1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(2);
    chk("rst_exec_res", 64'(result_q), 64'd0);
    chk("rst_exec_cnt", 64'(op_count), 64'd0);
    chk("rst_exec_pulse", 64'(rv_pulses - p0), 64'd0);

    // Random traffic: entries, occasional clear and rare reset.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 2) == 0, $urandom,
           $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
    end
    idle(ALU_LAT + 2);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
